// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: captures each finished frame
// (data plus parity-error flag), acknowledges the receiver with a one-cycle
// pulse, and presents the buffered frames to the register side as a
// show-ahead FIFO.
//
// Handshakes:
//   receiver side - rx_done_i is a level that stays high until acknowledged;
//     a frame is taken on the edge where the capture FSM is idle, rx_done_i
//     is high, the FIFO is not full and no flush is requested.
//     host_read_data_o is high for exactly the one cycle after that edge, and
//     the FSM then waits for rx_done_i to drop before it can capture again.
//   read side - rd_en_i is a pop request; it takes effect only when the FIFO
//     is not empty. rd_data_o / rd_perr_o always show the head entry (0 when
//     empty).
module uart_rx_fifo #(
   parameter int DEPTH    = 16,
   parameter int DATA_W   = 8,
   parameter int AF_LEVEL = 12
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       rx_done_i,
   input  logic [DATA_W-1:0]          rx_data_i,
   input  logic                       parity_error_i,
   output logic                       host_read_data_o,
   input  logic                       rd_en_i,
   input  logic                       flush_i,
   output logic [DATA_W-1:0]          rd_data_o,
   output logic                       rd_perr_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic                       almost_full_o,
   output logic [1:0]                 dbg_state_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      CAP_IDLE = 2'd0,
      CAP_ACK  = 2'd1,
      CAP_WAIT = 2'd2
   } cap_state_t;

   cap_state_t        state;
   logic [DATA_W:0]   mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [DATA_W:0]   head;
   logic              wr_en;
   logic              rd_fire;

   // The write decision looks only at the registered full flag, so a pop on
   // a full FIFO frees a slot that is used on the following cycle.
   assign wr_en   = (state == CAP_IDLE) && rx_done_i && !full_o && !flush_i;
   assign rd_fire = rd_en_i && !empty_o && !flush_i;

   // Capture handshake: idle -> ack pulse -> wait for the done flag to drop.
   // A flush does not interrupt an in-progress ack/wait, so the receiver is
   // always released.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= CAP_IDLE;
         host_read_data_o <= 1'b0;
      end else begin
         case (state)
            CAP_IDLE: begin
               if (wr_en) begin
                  state            <= CAP_ACK;
                  host_read_data_o <= 1'b1;
               end
            end
            CAP_ACK: begin
               state            <= CAP_WAIT;
               host_read_data_o <= 1'b0;
            end
            CAP_WAIT: begin
               host_read_data_o <= 1'b0;
               if (!rx_done_i) state <= CAP_IDLE;
            end
            default: begin
               state            <= CAP_IDLE;
               host_read_data_o <= 1'b0;
            end
         endcase
      end
   end

   // Frame storage; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem[wr_ptr] <= {parity_error_i, rx_data_i};
   end

   // Pointers and occupancy; flush outranks both write and read.
   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)   wr_ptr <= wr_ptr + AW'(1);
         if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_fire})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head          = mem[rd_ptr];
   assign count_o       = count;
   assign empty_o       = (count == '0);
   assign full_o        = (count == CW'(DEPTH));
   assign almost_full_o = (count >= CW'(AF_LEVEL));
   assign rd_data_o     = empty_o ? '0 : head[DATA_W-1:0];
   assign rd_perr_o     = empty_o ? 1'b0 : head[DATA_W];
   assign dbg_state_o   = state;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer directly downstream of the UART receiver. Captures each completed frame (data byte plus parity-error flag) when the receiver raises its done flag. Acknowledges the receiver with a one-cycle `host_read_data_o` pulse, which releases it to accept the next frame. Presents the buffered frames to the APB register block as a show-ahead FIFO.

## Interface

Parameters
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `DATA_W`, 8: data width captured from the receiver's `rx_data_o[DATA_W-1:0]`.
- `AF_LEVEL`, 12: `almost_full_o` asserts when occupancy ≥ `AF_LEVEL`; range 1..`DEPTH`.

Ports
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous reset, active high. One clock; reset is synchronous and active-high.
- `rx_done_i`  in  1: receiver frame-complete flag. Level signal; stays high until acknowledged.
- `rx_data_i`  in  `DATA_W`: received data, zero-extended by the receiver for 5/6/7-bit frames.
- `parity_error_i`  in  1: receiver parity error for the current frame.
- `host_read_data_o`  out  1: acknowledge to the receiver; high for exactly one cycle per captured frame.
- `rd_en_i`  in  1: pop request from the APB side.
- `flush_i`  in  1: discard all buffered entries.
- `rd_data_o`  out  `DATA_W`: head entry data; 0 when empty.
- `rd_perr_o`  out  1: head entry parity-error flag; 0 when empty.
- `count_o`  out  `$clog2(DEPTH)+1`: occupancy.
- `empty_o`  out  1: `count_o == 0`.
- `full_o`  out  1: `count_o == DEPTH`.
- `almost_full_o`  out  1: `count_o >= AF_LEVEL`.

## Operation

- Storage: `DEPTH` × (`DATA_W`+1) array holding `{perr, data}`. Write and read pointers are `$clog2(DEPTH)` bits wide and wrap naturally. A registered occupancy counter drives all flags.
- Capture FSM has three states: CAP_IDLE, CAP_ACK, CAP_WAIT.
  - CAP_IDLE → CAP_ACK when `rx_done_i && !full_o && !flush_i`. On that same edge, write `{parity_error_i, rx_data_i}` at the write pointer and advance the pointer.
  - CAP_IDLE holds while `full_o`. The frame stays in the receiver and is not acknowledged, so no data is lost in this block. The receiver blocks new frames while its done flag is high.
  - CAP_ACK → CAP_WAIT unconditionally. `host_read_data_o = (state == CAP_ACK)`.
  - CAP_WAIT → CAP_IDLE when `rx_done_i == 0`. This prevents a double capture of the same frame.
- Read: on `rd_en_i && !empty_o`, advance the read pointer. `rd_en_i` while empty is ignored; pointers and count are unchanged.
- Occupancy update:
  - write only: +1.
  - read only: −1.
  - write and read in the same cycle: unchanged.
  - The write decision uses the registered `full_o`. When full, a same-cycle pop does not enable a same-cycle write; the write occurs on the next cycle.
- Flush: `flush_i` has priority over write and read. It zeroes both pointers and the count on that edge and suppresses any capture that cycle. The FSM still completes an in-progress ACK/WAIT sequence, so the receiver is always released.
- Reset: FSM = CAP_IDLE, pointers = 0, count = 0.
  - Output values: `empty_o = 1`, `full_o = 0`, `almost_full_o = 0`, `host_read_data_o = 0`, `rd_data_o = 0`, `rd_perr_o = 0`.
  - Array contents are not reset.
  - Reset mid-handshake abandons the ACK. The receiver keeps its done flag high, and the frame is recaptured after reset.

## Timing

- Capture edge E (in CAP_IDLE with `rx_done_i` high).
  - `count_o`, `empty_o` and the flags update in the cycle after E.
  - `rd_data_o` shows the new entry in that same cycle if the FIFO was previously empty.
- `host_read_data_o` is high for the single cycle after E. The receiver drops `rx_done_i` one cycle later.
- Minimum spacing between captures is 3 cycles (IDLE, ACK, WAIT).
- Pop: head data moves to the next entry in the cycle after the pop edge. There is no read-data latency beyond show-ahead: `rd_data_o` and `rd_perr_o` are combinational from the head entry.
- All outputs except `rd_data_o` and `rd_perr_o` are registered or derived only from registered state.

## Test plan

- Reset then single frame: hold `rx_done_i=1` with `rx_data_i=8'hA5` and `parity_error_i=0`; drop `rx_done_i` one cycle after the ack.
  - Expect exactly one `host_read_data_o` pulse, one cycle after the capture edge.
  - Then `count_o=1`, `rd_data_o=8'hA5`, `rd_perr_o=0`.
  - After a pop: `empty_o=1`, `rd_data_o=0`.
- Stuck done flag: hold `rx_done_i=1` for 10 cycles.
  - Expect one capture and one ack pulse; `count_o=1`.
- Fill to full: 16 frames with data 0..15; frame 7 has `parity_error_i=1`.
  - `almost_full_o` rises when `count_o` reaches 12; `full_o` rises at 16.
  - A 17th `rx_done_i` gets no ack while full. After one pop it is captured and acked.
  - Drain order is 1..15 then the 17th frame. The popped frame 7 has `rd_perr_o=1`.
- Pointer wrap: do 40 write/pop pairs with data `8'h40+i`.
  - Every value pops in order; `count_o` never exceeds 1.
  - Add one simultaneous write and pop while count=3: `count_o` stays 3.
- Flush and empty pop: with `count_o=5`, pulse `flush_i` in the same cycle as `rx_done_i` rises.
  - Next cycle `count_o=0`, and no capture or ack occurs that cycle.
  - The frame is captured on the following IDLE cycle.
  - `rd_en_i` while empty leaves `count_o=0`.
- Reset mid-handshake: assert `reset` during CAP_ACK.
  - Outputs go to their reset values.
  - After reset is released with `rx_done_i` still high, the frame is captured and acked once.
